// File: rtl/ir_frame_decoder_pkg.sv
// ir_frame_decoder_pkg: frame field positions and FSM state encoding shared by the IR frame decoder
package ir_frame_decoder_pkg;
    localparam int ADDR_LSB  = 0;
    localparam int NADDR_LSB = 8;
    localparam int CMD_LSB   = 16;
    localparam int NCMD_LSB  = 24;
    localparam int FIELD_W   = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, HELD = 2'd2} state_t;
endpackage

// File: rtl/ir_hold_timer.sv
// ir_hold_timer: loadable down-counter that stops at zero and flags it
module ir_hold_timer #(
    parameter int HOLD_TICKS = 1100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam int W = $clog2(HOLD_TICKS + 1);
    logic [W-1:0] r_cnt;
    assign o_zero = r_cnt == '0;
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= W'(HOLD_TICKS);
        else if (i_dec && !o_zero)
            r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/ir_frame_decoder.sv
// ir_frame_decoder: validates NEC frames from the IR reader, publishes code strobes and tracks held keys
module ir_frame_decoder
    import ir_frame_decoder_pkg::*;
#(
    parameter int         HOLD_TICKS     = 1100,
    parameter bit         ADDR_FILTER_EN = 1'b0,
    parameter logic [7:0] ADDR_MATCH     = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avail,
    input  logic [31:0] frame,
    output logic [7:0]  cmd,
    output logic [7:0]  addr,
    output logic        cmd_valid,
    output logic        new_key,
    output logic        frame_err,
    output logic        key_held,
    output logic [7:0]  repeat_cnt
);
    logic               r_avail_q;
    logic [31:0]        r_frame;
    state_t             r_state, r_prev;
    logic               w_new_frame, w_valid, w_same, w_zero, w_hold_on;
    logic [FIELD_W-1:0] w_addr, w_naddr, w_cmd, w_ncmd;
    assign w_addr      = r_frame[ADDR_LSB +: FIELD_W];
    assign w_naddr     = r_frame[NADDR_LSB +: FIELD_W];
    assign w_cmd       = r_frame[CMD_LSB +: FIELD_W];
    assign w_ncmd      = r_frame[NCMD_LSB +: FIELD_W];
    assign w_new_frame = avail & ~r_avail_q;
    assign w_valid     = (w_naddr == ~w_addr) && (w_ncmd == ~w_cmd) && (!ADDR_FILTER_EN || w_addr == ADDR_MATCH);
    assign w_same      = r_prev == HELD && w_addr == addr && w_cmd == cmd;
    // a rejected frame only returns to HELD if the untouched timer still has time left
    assign w_hold_on   = r_prev == HELD && !w_zero;
    ir_hold_timer #(.HOLD_TICKS(HOLD_TICKS)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == CHECK && w_valid),
        .i_dec  (r_state != IDLE),
        .o_zero (w_zero)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_avail_q  <= 1'b0;
            r_frame    <= '0;
            r_state    <= IDLE;
            r_prev     <= IDLE;
            cmd        <= '0;
            addr       <= '0;
            cmd_valid  <= 1'b0;
            new_key    <= 1'b0;
            frame_err  <= 1'b0;
            key_held   <= 1'b0;
            repeat_cnt <= '0;
        end else begin
            r_avail_q <= avail;
            cmd_valid <= 1'b0;
            new_key   <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                IDLE: if (w_new_frame) begin
                    r_frame <= frame;
                    r_prev  <= IDLE;
                    r_state <= CHECK;
                end
                HELD: if (w_new_frame) begin
                    r_frame <= frame;
                    r_prev  <= HELD;
                    r_state <= CHECK;
                end else if (w_zero) begin
                    key_held <= 1'b0;
                    r_state  <= IDLE;
                end
                CHECK: if (w_valid) begin
                    cmd_valid  <= 1'b1;
                    key_held   <= 1'b1;
                    r_state    <= HELD;
                    new_key    <= !w_same;
                    cmd        <= w_cmd;
                    addr       <= w_addr;
                    repeat_cnt <= w_same ? repeat_cnt + {7'd0, repeat_cnt != 8'hFF} : 8'd0;
                end else begin
                    frame_err <= 1'b1;
                    key_held  <= w_hold_on;
                    r_state   <= w_hold_on ? HELD : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ir_frame_decoder.sv
// tb_ir_frame_decoder: directed scoreboard bench for the IR frame decoder
module tb_ir_frame_decoder;
    localparam int HOLD = 200;
    typedef struct {
        bit         err;
        logic [7:0] cmd;
        logic [7:0] addr;
        bit         nk;
        logic [7:0] rc;
        int         at;
    } exp_t;
    logic        clk, rst, avail, f_avail;
    logic [31:0] frame, f_frame;
    logic [7:0]  cmd, addr, repeat_cnt, f_cmd, f_addr, f_repeat_cnt;
    logic        cmd_valid, new_key, frame_err, key_held;
    logic        f_cmd_valid, f_new_key, f_frame_err, f_key_held;
    exp_t        sb[$];
    int          checks = 0, errors = 0, cyc = 0, last_acc = 0, f_ok = 0, f_bad = 0;

    ir_frame_decoder #(.HOLD_TICKS(HOLD)) u_dut (
        .clk(clk), .reset(rst), .avail(avail), .frame(frame),
        .cmd(cmd), .addr(addr), .cmd_valid(cmd_valid), .new_key(new_key),
        .frame_err(frame_err), .key_held(key_held), .repeat_cnt(repeat_cnt)
    );
    ir_frame_decoder #(.HOLD_TICKS(HOLD), .ADDR_FILTER_EN(1'b1), .ADDR_MATCH(8'h02)) u_flt (
        .clk(clk), .reset(rst), .avail(f_avail), .frame(f_frame),
        .cmd(f_cmd), .addr(f_addr), .cmd_valid(f_cmd_valid), .new_key(f_new_key),
        .frame_err(f_frame_err), .key_held(f_key_held), .repeat_cnt(f_repeat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (f_cmd_valid) f_ok++;
            if (f_frame_err) f_bad++;
            if (cmd_valid || frame_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {cmd_valid, frame_err}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_cycle", cyc, e.at);
                    chk("cmd_valid", cmd_valid, !e.err);
                    chk("frame_err", frame_err, e.err);
                    chk("new_key", new_key, e.nk);
                    chk("cmd", cmd, e.cmd);
                    chk("addr", addr, e.addr);
                    chk("repeat_cnt", repeat_cnt, e.rc);
                    if (!e.err) last_acc = cyc;
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] f, input int high, input bit err,
                        input logic [7:0] ec, input logic [7:0] ea, input bit nk, input logic [7:0] rc);
        frame = f;
        avail = 1'b1;
        sb.push_back('{err: err, cmd: ec, addr: ea, nk: nk, rc: rc, at: cyc + 2});
        tick(high);
        avail = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; avail = 1'b0; frame = '0; f_avail = 1'b0; f_frame = '0;
        tick(3);
        rst = 1'b0;
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_addr", addr, 8'h00);
        chk("rst_pulses", {cmd_valid, new_key, frame_err}, 3'b000);
        chk("rst_key_held", key_held, 1'b0);
        chk("rst_repeat", repeat_cnt, 8'h00);
        tick(2);
        // first key press, then three repeats 50 ticks apart
        send(32'hBF40_FE01, 1, 0, 8'h40, 8'h01, 1, 8'd0);
        chk("held_after_first", key_held, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick(47);
            send(32'hBF40_FE01, 1, 0, 8'h40, 8'h01, 0, 8'(i));
        end
        chk("repeat_3", repeat_cnt, 8'd3);
        tick(10);
        send(32'hBF41_FE01, 1, 1, 8'h40, 8'h01, 0, 8'd3);
        chk("held_after_bad", key_held, 1'b1);
        chk("cmd_after_bad", cmd, 8'h40);
        // release must follow the last accepted frame, not the rejected one
        tick(last_acc + HOLD - cyc);
        chk("held_before_expiry", key_held, 1'b1);
        tick(1);
        chk("released", key_held, 1'b0);
        chk("repeat_retained", repeat_cnt, 8'd3);
        chk("sb_empty_1", sb.size(), 0);
        tick(5);
        send(32'hBF40_FE01, 500, 0, 8'h40, 8'h01, 1, 8'd0);
        send(32'hBF40_FE01, 1, 0, 8'h40, 8'h01, 1, 8'd0);
        tick(20);
        send(32'hEF10_FE01, 1, 0, 8'h10, 8'h01, 1, 8'd0);
        tick(5);
        send(32'hEF10_FE01, 1, 0, 8'h10, 8'h01, 0, 8'd1);
        chk("held_new_code", key_held, 1'b1);
        chk("sb_empty_2", sb.size(), 0);
        // reset lands while the captured frame sits in CHECK
        frame = 32'hBF40_FE01;
        avail = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("midrst_pulses", {cmd_valid, new_key, frame_err}, 3'b000);
        chk("midrst_cmd", cmd, 8'h00);
        chk("midrst_addr", addr, 8'h00);
        chk("midrst_key_held", key_held, 1'b0);
        chk("midrst_repeat", repeat_cnt, 8'h00);
        rst = 1'b0;
        avail = 1'b0;
        tick(3);
        chk("midrst_no_late_pulse", {cmd_valid, frame_err}, 2'b00);
        send(32'hBF40_FE01, 1, 0, 8'h40, 8'h01, 1, 8'd0);
        for (int i = 1; i <= 300; i++)
            send(32'hBF40_FE01, 1, 0, 8'h40, 8'h01, 0, (i > 255) ? 8'd255 : 8'(i));
        chk("repeat_saturated", repeat_cnt, 8'd255);
        chk("sb_empty_3", sb.size(), 0);
        // address filter: addr 01 rejected, addr 02 accepted
        f_frame = 32'hBF40_FE01;
        f_avail = 1'b1;
        tick(1);
        f_avail = 1'b0;
        tick(4);
        chk("flt_reject_err", f_bad, 1);
        chk("flt_reject_no_valid", f_ok, 0);
        f_frame = 32'hBF40_FD02;
        f_avail = 1'b1;
        tick(1);
        f_avail = 1'b0;
        tick(4);
        chk("flt_accept_valid", f_ok, 1);
        chk("flt_accept_no_err", f_bad, 1);
        chk("flt_cmd", f_cmd, 8'h40);
        chk("flt_addr", f_addr, 8'h02);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
